wishbone_classic_arbiter: RTL
=============================

Name: wishbone_classic_arbiter

Overview:
Round-robin arbiter that lets NUM_CTRL Wishbone B4 classic controllers share one classic device port, such as a wishbone_classic-based peripheral. It grants bus ownership for a whole cycle: from the granted controller's cyc rising until that cyc falls. It also enforces a watchdog that terminates stalled transfers with err. It sits between CPU/DMA-style controllers and a single peripheral bus segment.

Parameters:
NUM_CTRL, 2, number of controller ports (2..16)
ADR_WIDTH, 16, address width
DAT_WIDTH, 8, data width
TIMEOUT, 255, max cycles a strobe may wait for ack/err/rty; 0 disables the watchdog

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_ni  in  1  synchronous active-low reset
ctrl_cyc_i  in  NUM_CTRL  per-controller cyc
ctrl_stb_i  in  NUM_CTRL  per-controller stb
ctrl_we_i  in  NUM_CTRL  per-controller we
ctrl_adr_i  in  NUM_CTRL*ADR_WIDTH  packed addresses; controller i at [i*ADR_WIDTH +: ADR_WIDTH]
ctrl_dat_i  in  NUM_CTRL*DAT_WIDTH  packed write data, packed the same way
ctrl_dat_o  out  DAT_WIDTH  read data, broadcast to all controllers (= dev_dat_i)
ctrl_ack_o  out  NUM_CTRL  per-controller ack
ctrl_err_o  out  NUM_CTRL  per-controller err
ctrl_rty_o  out  NUM_CTRL  per-controller rty
dev_cyc_o  out  1  device cyc
dev_stb_o  out  1  device stb
dev_we_o  out  1  device we
dev_adr_o  out  ADR_WIDTH  device address
dev_dat_o  out  DAT_WIDTH  device write data
dev_dat_i  in  DAT_WIDTH  device read data
dev_ack_i  in  1  device ack
dev_err_i  in  1  device err
dev_rty_i  in  1  device rty
grant_o  out  NUM_CTRL  registered one-hot owner; all zero when idle

Behaviour:
- Reset (rst_ni=0 at an edge):
  - state=IDLE, grant_o=0, last-granted pointer=NUM_CTRL-1 (controller 0 wins the first arbitration), watchdog=0.
  - All dev_* outputs and ctrl_ack/err/rty_o are 0 while grant_o=0.
  - Reset mid-cycle drops dev_cyc_o the cycle after the reset edge. No ack/err is generated for the aborted transfer.
- States: IDLE, OWN, ABORT.
- IDLE:
  - At each edge, if any ctrl_cyc_i is set, grant the first requester searching upward from pointer+1 (modulo NUM_CTRL).
  - Set grant_o one-hot, update the pointer, go to OWN.
  - Latency: cyc sampled at edge k gives grant_o and dev_cyc_o high after edge k.
- OWN:
  - dev_cyc/stb/we/adr/dat_o are combinational muxes of the granted controller's inputs.
  - dev_ack/err/rty_i are routed combinationally to the granted controller's bit only; all other bits are 0.
  - Ownership persists across multiple strobes while the granted cyc stays high (classic block cycles). No preemption.
  - Granted ctrl_cyc_i low at an edge: grant_o cleared, go to IDLE. There is one idle cycle before the next grant.
  - A controller that drops cyc and re-raises it competes again at lowest priority.
- Watchdog (TIMEOUT>0):
  - Counter clears whenever dev_stb_o is 0 or any of ack/err/rty is set.
  - Otherwise it increments each cycle while dev_stb_o is 1. Counter width is clog2(TIMEOUT+1).
  - When the count equals TIMEOUT at an edge, go to ABORT.
- ABORT:
  - dev_cyc_o=dev_stb_o=0; device responses are ignored.
  - Granted controller receives ctrl_err_o=1 for exactly one cycle (the first ABORT cycle), then 0.
  - Remain in ABORT until the granted ctrl_cyc_i is sampled low, then go to IDLE and clear grant_o.
- Simultaneous events:
  - A device ack in the same cycle the count reaches TIMEOUT wins: the transfer completes and there is no abort.
  - The granted cyc falling in the same cycle as the abort edge: go to IDLE, no err.
- Requests from non-granted controllers are ignored until the owner releases. Their ack/err/rty bits stay 0.

Test Plan:
- Single controller: ctrl 1 cyc/stb, we=1, adr=0x0010, dat=0xA5; device acks on its 2nd stb cycle -> grant_o=0b10 one cycle after request; dev_adr_o=0x0010, dev_dat_o=0xA5; ctrl_ack_o=0b10 for one cycle; grant cleared the cycle after cyc drops.
- Round robin: NUM_CTRL=4, all cyc held high, each does one read then drops cyc for 1 cycle -> grant order 0,1,2,3,0 with exactly one idle cycle between grants.
- Block cycle: ctrl 0 issues 3 back-to-back reads (adr 0x20..0x22, dev_dat_i 0x11,0x22,0x33) with ctrl 1 requesting throughout -> ctrl 0 keeps the grant for all 3; ctrl_dat_o matches; ctrl 1 granted only after ctrl 0's cyc falls.
- Timeout: TIMEOUT=4, device never responds -> dev_cyc_o low after 4 stalled cycles; ctrl_err_o pulses one cycle for the owner; grant held until the owner drops cyc; a new grant succeeds afterwards.
- Timeout race: TIMEOUT=4, dev_ack_i on the 4th stalled cycle -> normal ack, no err, no ABORT.
- Reset mid-transfer: rst_ni=0 while ctrl 2 owns the bus with stb high -> after the edge grant_o=0 and dev_cyc_o=0; the next arbitration picks ctrl 0 when ctrl 0 and ctrl 2 request together.

Source files
------------

// File: rtl/wishbone_classic_arbiter_if.sv
// Bus bundle between NUM_CTRL Wishbone classic controllers, the arbiter and one device port.
// The slave modport is the arbiter's view; master is the controllers-plus-device environment.
interface wishbone_classic_arbiter_if #(
  parameter int NUM_CTRL  = 2,
  parameter int ADR_WIDTH = 16,
  parameter int DAT_WIDTH = 8
);
  logic [NUM_CTRL-1:0]           ctrl_cyc_i;
  logic [NUM_CTRL-1:0]           ctrl_stb_i;
  logic [NUM_CTRL-1:0]           ctrl_we_i;
  logic [NUM_CTRL*ADR_WIDTH-1:0] ctrl_adr_i;
  logic [NUM_CTRL*DAT_WIDTH-1:0] ctrl_dat_i;
  logic [DAT_WIDTH-1:0]          ctrl_dat_o;
  logic [NUM_CTRL-1:0]           ctrl_ack_o;
  logic [NUM_CTRL-1:0]           ctrl_err_o;
  logic [NUM_CTRL-1:0]           ctrl_rty_o;
  logic                          dev_cyc_o;
  logic                          dev_stb_o;
  logic                          dev_we_o;
  logic [ADR_WIDTH-1:0]          dev_adr_o;
  logic [DAT_WIDTH-1:0]          dev_dat_o;
  logic [DAT_WIDTH-1:0]          dev_dat_i;
  logic                          dev_ack_i;
  logic                          dev_err_i;
  logic                          dev_rty_i;

  modport slave (
    input  ctrl_cyc_i, ctrl_stb_i, ctrl_we_i, ctrl_adr_i, ctrl_dat_i,
    output ctrl_dat_o, ctrl_ack_o, ctrl_err_o, ctrl_rty_o,
    output dev_cyc_o, dev_stb_o, dev_we_o, dev_adr_o, dev_dat_o,
    input  dev_dat_i, dev_ack_i, dev_err_i, dev_rty_i
  );

  modport master (
    output ctrl_cyc_i, ctrl_stb_i, ctrl_we_i, ctrl_adr_i, ctrl_dat_i,
    input  ctrl_dat_o, ctrl_ack_o, ctrl_err_o, ctrl_rty_o,
    input  dev_cyc_o, dev_stb_o, dev_we_o, dev_adr_o, dev_dat_o,
    output dev_dat_i, dev_ack_i, dev_err_i, dev_rty_i
  );
endinterface

// File: rtl/wishbone_classic_arbiter.sv
// Round-robin arbiter granting a shared Wishbone classic device port for whole cycles,
// with a watchdog that aborts stalled strobes and answers the owner with a single err.
module wishbone_classic_arbiter #(
  parameter int NUM_CTRL  = 2,
  parameter int ADR_WIDTH = 16,
  parameter int DAT_WIDTH = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  wishbone_classic_arbiter_if.slave bus,
  output logic [NUM_CTRL-1:0]   grant_o
);
  localparam int IDX_W = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, OWN, ABORT} state_e;

  state_e              state_q, state_d;
  logic [NUM_CTRL-1:0] grant_q, grant_d;
  // Owner index while granted; doubles as the last-granted round-robin pointer.
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    wdog_q, wdog_d;
  logic                err_pend_q, err_pend_d;

  logic own_cyc, own_stb, dev_resp, stalled, wdog_hit, found;
  int   cand;

  assign own_cyc  = bus.ctrl_cyc_i[idx_q];
  assign own_stb  = bus.ctrl_stb_i[idx_q];
  assign dev_resp = bus.dev_ack_i | bus.dev_err_i | bus.dev_rty_i;
  assign stalled  = (state_q == OWN) && own_stb && !dev_resp;
  // Abort on the edge at which the stall count would reach TIMEOUT; a response that cycle wins.
  assign wdog_hit = (TIMEOUT > 0) && stalled && ((int'(wdog_q) + 1) == TIMEOUT);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    idx_d      = idx_q;
    wdog_d     = '0;
    err_pend_d = 1'b0;
    found      = 1'b0;
    cand       = 0;
    unique case (state_q)
      IDLE: begin
        for (int k = 1; k <= NUM_CTRL; k++) begin
          cand = (int'(idx_q) + k) % NUM_CTRL;
          if (!found && bus.ctrl_cyc_i[cand]) begin
            found          = 1'b1;
            idx_d          = IDX_W'(cand);
            grant_d        = '0;
            grant_d[cand]  = 1'b1;
            state_d        = OWN;
          end
        end
      end
      OWN: begin
        if (!own_cyc) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (wdog_hit) begin
          state_d    = ABORT;
          err_pend_d = 1'b1;
        end else if (stalled && (TIMEOUT > 0)) begin
          wdog_d = wdog_q + CNT_W'(1);
        end
      end
      ABORT: begin
        if (!own_cyc) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      idx_q      <= IDX_W'(NUM_CTRL - 1);
      wdog_q     <= '0;
      err_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      idx_q      <= idx_d;
      wdog_q     <= wdog_d;
      err_pend_q <= err_pend_d;
    end
  end

  assign grant_o        = grant_q;
  assign bus.ctrl_dat_o = bus.dev_dat_i;

  // Device side follows the owner only in OWN; ABORT isolates the device and ignores its responses.
  always_comb begin
    bus.dev_cyc_o  = 1'b0;
    bus.dev_stb_o  = 1'b0;
    bus.dev_we_o   = 1'b0;
    bus.dev_adr_o  = '0;
    bus.dev_dat_o  = '0;
    bus.ctrl_ack_o = '0;
    bus.ctrl_err_o = '0;
    bus.ctrl_rty_o = '0;
    if (state_q == OWN) begin
      bus.dev_cyc_o  = own_cyc;
      bus.dev_stb_o  = own_stb;
      bus.dev_we_o   = bus.ctrl_we_i[idx_q];
      bus.dev_adr_o  = bus.ctrl_adr_i[int'(idx_q)*ADR_WIDTH +: ADR_WIDTH];
      bus.dev_dat_o  = bus.ctrl_dat_i[int'(idx_q)*DAT_WIDTH +: DAT_WIDTH];
      bus.ctrl_ack_o = grant_q & {NUM_CTRL{bus.dev_ack_i}};
      bus.ctrl_err_o = grant_q & {NUM_CTRL{bus.dev_err_i}};
      bus.ctrl_rty_o = grant_q & {NUM_CTRL{bus.dev_rty_i}};
    end else if (state_q == ABORT) begin
      bus.ctrl_err_o = grant_q & {NUM_CTRL{err_pend_q}};
    end
  end
endmodule
